// File: rtl/par2ser_pkg.sv
// Shared types and width helpers for the par2ser parallel-to-serial shifter.
package par2ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit counter must be able to hold DATA_WIDTH (one past the last bit index).
  function automatic int bcnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  function automatic int div_w(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/par2ser_bit_tick_gen.sv
// Bit-period divider: tick is high on the last clock of every serial bit period.
module bit_tick_gen
  import par2ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DIVW = div_w(CLKS_PER_BIT);
  localparam logic [DIVW-1:0] LAST = DIVW'(CLKS_PER_BIT - 1);

  logic [DIVW-1:0] div;

  // With one clock per bit the divider stays at 0 and tick is permanently high.
  assign tick = (div == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) div <= '0;
    else                      div <= div + 1'b1;
  end

endmodule

// File: rtl/par2ser.sv
// Parallel-in, MSB-first serial-out shifter with valid/ready input and framing strobes.
// Define PAR2SER_PARITY_EN to append an even-parity bit period to every frame.
module par2ser
  import par2ser_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_first,
  output logic                  ser_last
);

  localparam int BW = bcnt_w(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic                  tick, final_clk, accept;
  logic                  out_n, valid_n, first_n, last_n;

`ifdef PAR2SER_PARITY_EN
  logic par, par_n;
  assign final_clk = (state == PARITY) && tick;
`else
  assign final_clk = (state == SHIFT) && (bcnt == LAST_BIT) && tick;
`endif

  assign in_ready = !rst && ((state == IDLE) || final_clk);
  assign accept   = in_valid && in_ready;

  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept || (state == IDLE)),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n  = bcnt;
`ifdef PAR2SER_PARITY_EN
    par_n   = par;
`endif
    if (accept) begin
      state_n = SHIFT;
      shreg_n = in_data;
      bcnt_n  = '0;
`ifdef PAR2SER_PARITY_EN
      par_n   = ^in_data;
`endif
    end else begin
      case (state)
        SHIFT: if (tick) begin
          shreg_n = {shreg[DATA_WIDTH-2:0], 1'b0};
          bcnt_n  = bcnt + 1'b1;
`ifdef PAR2SER_PARITY_EN
          if (bcnt == LAST_BIT) state_n = PARITY;
`else
          if (bcnt == LAST_BIT) state_n = IDLE;
`endif
        end
`ifdef PAR2SER_PARITY_EN
        PARITY: if (tick) state_n = IDLE;
`endif
        default: ;
      endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    valid_n = (state_n != IDLE);
    first_n = (state_n == SHIFT) && (bcnt_n == '0);
    out_n   = (state_n == SHIFT) && shreg_n[DATA_WIDTH-1];
`ifdef PAR2SER_PARITY_EN
    if (state_n == PARITY) out_n = par_n;
    last_n  = (state_n == PARITY);
`else
    last_n  = (state_n == SHIFT) && (bcnt_n == LAST_BIT);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
`ifdef PAR2SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bcnt      <= bcnt_n;
      ser_out   <= out_n;
      ser_valid <= valid_n;
      ser_first <= first_n;
      ser_last  <= last_n;
`ifdef PAR2SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_par2ser.sv
// Bench for par2ser: two instances (1 and 3 clocks per bit) sharing stimulus, each
// checked every cycle against a queue of expected bit periods, plus directed literals.
module tb_par2ser;

`ifdef PAR2SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct packed {
    logic o;
    logic f;
    logic l;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       chk_en;
  wire  [1:0] rdy, so, sv, sf, sl;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int CPB = (g == 0) ? 1 : 3;
    ent_t q[$];

    par2ser #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .ser_out   (so[g]),
      .ser_valid (sv[g]),
      .ser_first (sf[g]),
      .ser_last  (sl[g])
    );

    // q[0] is what the outputs must show during the current cycle.
    always @(posedge clk) begin
      if (rst) q.delete();
      else begin
        logic acc;
        acc = in_valid && (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (acc)
          for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++) begin
              ent_t e;
              e.o = (b < 8) ? in_data[7-b] : ^in_data;
              e.f = (b == 0);
              e.l = (b == NB - 1);
              q.push_back(e);
            end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        logic [4:0] exp_v, act_v;
        if (q.size() == 0) exp_v = {4'b0000, ~rst};
        else exp_v = {1'b1, q[0].o, q[0].f, q[0].l, (~rst) & (q.size() == 1)};
        act_v = {sv[g], so[g], sf[g], sl[g], rdy[g]};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL model%0d t=%0t {valid,out,first,last,ready} got=%b want=%b",
                   g, $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Entered just after a posedge with instance inst idle; bit i of each vector is cycle i
  // after the first accept. d1 is offered right after d0 is taken (when nwords==2).
  task automatic capture(input int inst, input logic [7:0] d0, input logic [7:0] d1,
                         input int nwords, input int n,
                         output logic [63:0] v, output logic [63:0] o, output logic [63:0] f,
                         output logic [63:0] l, output logic [63:0] r);
    int  acc;
    logic take;
    acc = 0; v = '0; o = '0; f = '0; l = '0; r = '0;
    in_valid = 1'b1;
    in_data  = d0;
    for (int i = -1; i < n; i++) begin
      @(negedge clk);
      if (i >= 0) begin
        v[i] = sv[inst]; o[i] = so[inst]; f[i] = sf[inst];
        l[i] = sl[inst]; r[i] = rdy[inst];
      end
      take = in_valid && rdy[inst];
      step();
      if (take) begin
        acc++;
        if (acc < nwords) in_data = d1;
        else in_valid = 1'b0;
      end
    end
  endtask

  logic [63:0] v, o, f, l, r, m;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; chk_en = 1'b0;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_outputs", {58'd0, sv, so, rdy}, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {62'd0, rdy}, 64'd3);
    step();

    // single word, one clock per bit
    capture(0, 8'hA5, 8'h00, 1, NB + 2, v, o, f, l, r);
    m = (64'd1 << (NB + 2)) - 1;
    check("t1_data", o & 64'hFF, 64'hA5);
    check("t1_first", f & m, 64'h1);
    check("t1_last", l & m, 64'd1 << (NB - 1));
    check("t1_valid", v & m, (64'd1 << NB) - 1);
    check("t1_ready", r & m, (64'd1 << (NB - 1)) | (64'd1 << NB) | (64'd1 << (NB + 1)));
    idle(40);

    // back-to-back words with in_valid held
    capture(0, 8'hFF, 8'h00, 2, 2 * NB + 2, v, o, f, l, r);
    m = (64'd1 << (2 * NB + 2)) - 1;
    check("t2_data", o & m, 64'hFF);
    check("t2_valid", v & m, (64'd1 << (2 * NB)) - 1);
    check("t2_first", f & m, 64'h1 | (64'd1 << NB));
    check("t2_ready", r & m, (64'd1 << (NB - 1)) | (64'd1 << (2 * NB - 1)) |
                             (64'd1 << (2 * NB)) | (64'd1 << (2 * NB + 1)));
    idle(40);

    // three clocks per bit
    capture(1, 8'h81, 8'h00, 1, 3 * NB + 2, v, o, f, l, r);
    m = (64'd1 << (3 * NB + 2)) - 1;
    check("t3_data", o & 64'hFFFFFF, 64'hE00007);
    check("t3_valid", v & m, (64'd1 << (3 * NB)) - 1);
    check("t3_first", f & m, 64'h7);
    check("t3_last", l & m, 64'h7 << (3 * (NB - 1)));
    idle(40);

    // second word waits for the final-clock slot
    capture(0, 8'h5A, 8'h3C, 2, 2 * NB + 2, v, o, f, l, r);
    m = (64'd1 << (2 * NB + 2)) - 1;
    check("t4_data", o & m, (64'h3C << NB) | 64'h5A);
    check("t4_valid", v & m, (64'd1 << (2 * NB)) - 1);
    idle(40);

    // reset in the middle of a frame
    in_valid = 1'b1; in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    @(negedge clk);
    check("t5_midframe_valid", {63'd0, sv[0]}, 64'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_after_reset", {61'd0, sv[0], so[0], rdy[0]}, 64'd1);
    step();
    idle(40);
    capture(0, 8'h01, 8'h00, 1, NB + 2, v, o, f, l, r);
    m = (64'd1 << (NB + 2)) - 1;
    check("t5_new_word", o & 64'hFF, 64'h80);
    check("t5_new_valid", v & m, (64'd1 << NB) - 1);
    idle(40);

`ifdef PAR2SER_PARITY_EN
    capture(0, 8'h07, 8'h00, 1, NB + 2, v, o, f, l, r);
    m = (64'd1 << (NB + 2)) - 1;
    check("t6_par1", o & 64'h1FF, 64'h1E0);
    check("t6_last", l & m, 64'h100);
    idle(40);
    capture(0, 8'h03, 8'h00, 1, NB + 2, v, o, f, l, r);
    check("t6_par0", o & 64'h1FF, 64'h0C0);
    idle(40);
`endif

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      step();
    end
    rst = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
